// File: rtl/dma_protocol_monitor.sv
// dma_protocol_monitor
//   Run-time protocol checker that sits beside the DMA controller. Each cycle
//   it evaluates eight checks (E0..E7) on the sampled pins and timing-and-
//   control state. Results are registered one cycle later as sticky flags, a
//   first-failure index, saturating counters and sticky coverage bits.
//
// Ports
//   CLK, RESET          clock, synchronous active-high reset
//   CS_N                chip select; the transition check is skipped while high
//   HRQ, HLDA           hold request / acknowledge (watchdog)
//   DREQ, DACK          per-channel request / acknowledge
//   AEN, ADSTB          address enable / strobe
//   IOR_N..MEMW_N       active-low bus strobes
//   tc_state            one-hot controller state (SI,SO,S1,S2,S3,S4 = bit0..5)
//   err_clr             clears err_sticky, err_first_vld, err_count
//   err_sticky          sticky per-check flags
//   err_pulse           one cycle after any failing cycle
//   err_first/_vld      lowest failing index of the first failing cycle
//   err_count           failing cycles, saturating
//   xfer_count          completed transfers per channel, saturating
//   cov_sticky          states visited, S4->S1 taken, watchdog half-way
module dma_protocol_monitor #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 16,
    parameter int WDOG_CYC    = 64,
    parameter int ALLOW_S3    = 1,
    parameter int ALLOW_BLOCK = 1
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     CS_N,
    input  logic                     HRQ,
    input  logic                     HLDA,
    input  logic [NUM_CH-1:0]        DREQ,
    input  logic [NUM_CH-1:0]        DACK,
    input  logic                     AEN,
    input  logic                     ADSTB,
    input  logic                     IOR_N,
    input  logic                     IOW_N,
    input  logic                     MEMR_N,
    input  logic                     MEMW_N,
    input  logic [5:0]               tc_state,
    input  logic                     err_clr,
    output logic [7:0]               err_sticky,
    output logic                     err_pulse,
    output logic [2:0]               err_first,
    output logic                     err_first_vld,
    output logic [CNT_W-1:0]         err_count,
    output logic [NUM_CH*CNT_W-1:0]  xfer_count,
    output logic [7:0]               cov_sticky
);

    localparam logic [5:0] ST_SI = 6'b000001;
    localparam logic [5:0] ST_SO = 6'b000010;
    localparam logic [5:0] ST_S1 = 6'b000100;
    localparam logic [5:0] ST_S2 = 6'b001000;
    localparam logic [5:0] ST_S3 = 6'b010000;
    localparam logic [5:0] ST_S4 = 6'b100000;
    localparam int         WD_W  = $clog2(WDOG_CYC + 1);

    logic [5:0]                    prev_state;  // last legal state seen
    logic [5:0]                    last_tc;     // raw state of the previous cycle
    logic [NUM_CH-1:0]             grant;       // one-hot latched grant, 0 = none
    logic [NUM_CH-1:0]             seen;        // DACK history of current transfer
    logic [WD_W-1:0]               wdog_cnt;
    logic                          first_cyc;
    logic [NUM_CH-1:0][CNT_W-1:0]  xfer_q;

    logic              state_ok, trans_ok, so_entry, in_xfer, s4_exit;
    logic              blk_taken, wd_half, any_fail, vld_base;
    logic [7:0]        fails;
    logic [2:0]        first_idx;
    logic [CNT_W-1:0]  cnt_base, cnt_next;

    always_comb begin
        state_ok = 1'b0;
        case (tc_state)
            ST_SI, ST_SO, ST_S1, ST_S2, ST_S4: state_ok = 1'b1;
            ST_S3:                             state_ok = (ALLOW_S3 != 0);
            default:                           state_ok = 1'b0;
        endcase

        trans_ok = 1'b0;
        case (prev_state)
            ST_SI: trans_ok = (tc_state == ST_SI) || (tc_state == ST_SO);
            ST_SO: trans_ok = (tc_state == ST_SO) || (tc_state == ST_S1);
            ST_S1: trans_ok = (tc_state == ST_S2);
            ST_S2: trans_ok = (tc_state == ST_S4) || ((ALLOW_S3 != 0) && (tc_state == ST_S3));
            ST_S3: trans_ok = (ALLOW_S3 != 0) && (tc_state == ST_S4);
            ST_S4: trans_ok = (tc_state == ST_SI) || ((ALLOW_BLOCK != 0) && (tc_state == ST_S1));
            default: trans_ok = 1'b0;
        endcase

        so_entry  = (tc_state == ST_SO) && (prev_state != ST_SO);
        in_xfer   = (tc_state == ST_S1) || (tc_state == ST_S2) ||
                    (tc_state == ST_S3) || (tc_state == ST_S4);
        s4_exit   = (last_tc == ST_S4) && (tc_state != ST_S4);
        blk_taken = (prev_state == ST_S4) && (tc_state == ST_S1);
        wd_half   = (wdog_cnt == WD_W'(WDOG_CYC / 2));

        fails    = '0;
        fails[0] = !state_ok;
        // An illegal code says nothing useful about the transition, so E0 masks E1.
        fails[1] = state_ok && !CS_N && !trans_ok;
        fails[2] = (DACK & (DACK - NUM_CH'(1))) != '0;
        fails[3] = (DACK & ~grant) != '0;
        fails[4] = (!IOR_N && !IOW_N) || (!MEMR_N && !MEMW_N);
        fails[5] = !AEN && (!IOR_N || !IOW_N || !MEMR_N || !MEMW_N || ADSTB);
        fails[6] = (wdog_cnt == WD_W'(WDOG_CYC));
        fails[7] = first_cyc && ((tc_state != ST_SI) || (DACK != '0));
        any_fail = fails != '0;

        first_idx = 3'd0;
        for (int k = 7; k >= 0; k--)
            if (fails[k]) first_idx = 3'(k);

        // err_clr acts before the new failure is recorded.
        cnt_base = err_clr ? '0 : err_count;
        vld_base = err_clr ? 1'b0 : err_first_vld;
        cnt_next = (any_fail && (cnt_base != '1)) ? cnt_base + CNT_W'(1) : cnt_base;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            prev_state    <= ST_SI;
            last_tc       <= ST_SI;
            grant         <= '0;
            seen          <= '0;
            wdog_cnt      <= '0;
            first_cyc     <= 1'b1;
            xfer_q        <= '0;
            err_sticky    <= '0;
            err_pulse     <= 1'b0;
            err_first     <= '0;
            err_first_vld <= 1'b0;
            err_count     <= '0;
            cov_sticky    <= '0;
        end else begin
            if (state_ok) prev_state <= tc_state;
            last_tc   <= tc_state;
            first_cyc <= 1'b0;

            // Lowest set DREQ bit: x & -x isolates it; zero means no grant.
            if (so_entry) grant <= DREQ & (~DREQ + NUM_CH'(1));

            if (HRQ && !HLDA)
                wdog_cnt <= fails[6] ? wdog_cnt : wdog_cnt + WD_W'(1);
            else
                wdog_cnt <= '0;

            for (int i = 0; i < NUM_CH; i++)
                if (s4_exit && seen[i] && (xfer_q[i] != '1))
                    xfer_q[i] <= xfer_q[i] + CNT_W'(1);
            // On S4->S1 the old transfer is closed and this cycle starts the next.
            seen <= in_xfer ? ((s4_exit ? '0 : seen) | DACK) : '0;

            err_pulse  <= any_fail;
            err_sticky <= (err_clr ? 8'h00 : err_sticky) | fails;
            err_count  <= cnt_next;
            if (any_fail && !vld_base) begin
                err_first     <= first_idx;
                err_first_vld <= 1'b1;
            end else begin
                err_first_vld <= vld_base;
            end

            cov_sticky <= cov_sticky | {wd_half, blk_taken, (state_ok ? tc_state : 6'b0)};
        end
    end

    assign xfer_count = xfer_q;

endmodule

// File: tb/tb_dma_protocol_monitor.sv
// Bench for dma_protocol_monitor: directed steps followed by a randomized run,
// every step compared against a behavioural model of the checker rules.
module tb_dma_protocol_monitor;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 8;
    localparam int WDOG   = 64;
    localparam int CMAX   = (1 << CNT_W) - 1;

    localparam logic [5:0] SI = 6'b000001;
    localparam logic [5:0] SO = 6'b000010;
    localparam logic [5:0] S1 = 6'b000100;
    localparam logic [5:0] S2 = 6'b001000;
    localparam logic [5:0] S3 = 6'b010000;
    localparam logic [5:0] S4 = 6'b100000;

    logic clk = 1'b0;
    logic rst, cs_n, hrq, hlda, aen, adstb, ior_n, iow_n, memr_n, memw_n, err_clr;
    logic [NUM_CH-1:0] dreq, dack;
    logic [5:0] tc;
    logic [7:0] err_sticky, cov_sticky;
    logic err_pulse, err_first_vld;
    logic [2:0] err_first;
    logic [CNT_W-1:0] err_count;
    logic [NUM_CH*CNT_W-1:0] xfer_count;

    always #5 clk = ~clk;

    dma_protocol_monitor #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .WDOG_CYC(WDOG), .ALLOW_S3(1), .ALLOW_BLOCK(1)
    ) dut (
        .CLK(clk), .RESET(rst), .CS_N(cs_n), .HRQ(hrq), .HLDA(hlda),
        .DREQ(dreq), .DACK(dack), .AEN(aen), .ADSTB(adstb),
        .IOR_N(ior_n), .IOW_N(iow_n), .MEMR_N(memr_n), .MEMW_N(memw_n),
        .tc_state(tc), .err_clr(err_clr),
        .err_sticky(err_sticky), .err_pulse(err_pulse), .err_first(err_first),
        .err_first_vld(err_first_vld), .err_count(err_count),
        .xfer_count(xfer_count), .cov_sticky(cov_sticky)
    );

    int passed = 0;
    int total  = 0;

    // Model state: states are indices 0..5 (SI,SO,S1,S2,S3,S4), grant -1 = none.
    int   m_prev, m_grant, m_wd, m_first, m_cnt;
    int   m_xfer[NUM_CH];
    bit   m_after, m_pulse, m_fv;
    logic [5:0] m_last;
    bit   [NUM_CH-1:0] m_seen;
    logic [7:0] m_sticky, m_cov;

    // Legal transitions as (from,to) index pairs.
    int lf[10] = '{0, 0, 1, 1, 2, 3, 3, 4, 5, 5};
    int lt[10] = '{0, 1, 1, 2, 3, 5, 4, 5, 0, 2};

    function automatic int st_idx(input logic [5:0] ts);
        for (int k = 0; k < 6; k++)
            if (ts == (6'b000001 << k)) return k;
        return -1;
    endfunction

    function automatic bit legal(input int a, input int b);
        for (int k = 0; k < 10; k++)
            if (lf[k] == a && lt[k] == b) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_step();
        bit [7:0] f;
        int idx;
        if (rst) begin
            m_prev = 0; m_grant = -1; m_wd = 0; m_after = 1; m_last = SI; m_seen = '0;
            for (int i = 0; i < NUM_CH; i++) m_xfer[i] = 0;
            m_sticky = 0; m_cov = 0; m_pulse = 0; m_first = 0; m_fv = 0; m_cnt = 0;
            return;
        end
        idx  = st_idx(tc);
        f    = '0;
        f[0] = (idx < 0);
        f[1] = (idx >= 0) && !cs_n && !legal(m_prev, idx);
        f[2] = $countones(dack) > 1;
        for (int i = 0; i < NUM_CH; i++)
            if (dack[i] && i != m_grant) f[3] = 1'b1;
        f[4] = (!ior_n && !iow_n) || (!memr_n && !memw_n);
        f[5] = !aen && (!ior_n || !iow_n || !memr_n || !memw_n || adstb);
        f[6] = (m_wd == WDOG);
        f[7] = m_after && (tc != SI || dack != '0);

        if (idx >= 0) m_cov[idx] = 1'b1;
        if (idx == 2 && m_prev == 5) m_cov[6] = 1'b1;
        if (m_wd == WDOG / 2) m_cov[7] = 1'b1;

        if (idx == 1 && m_prev != 1) begin
            m_grant = -1;
            for (int i = NUM_CH - 1; i >= 0; i--)
                if (dreq[i]) m_grant = i;
        end
        if (idx >= 0) m_prev = idx;
        m_wd = (hrq && !hlda) ? ((m_wd < WDOG) ? m_wd + 1 : WDOG) : 0;

        if (m_last == S4 && tc != S4) begin
            for (int i = 0; i < NUM_CH; i++)
                if (m_seen[i] && m_xfer[i] < CMAX) m_xfer[i]++;
            m_seen = '0;
        end
        if (tc == S1 || tc == S2 || tc == S3 || tc == S4) m_seen |= dack;
        else m_seen = '0;
        m_last  = tc;
        m_after = 0;

        if (err_clr) begin m_sticky = 0; m_cnt = 0; m_fv = 0; end
        m_pulse = (f != 0);
        if (f != 0) begin
            m_sticky |= f;
            if (m_cnt < CMAX) m_cnt++;
            if (!m_fv) begin
                m_fv = 1;
                for (int k = 7; k >= 0; k--) if (f[k]) m_first = k;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_model();
        chk("err_sticky", 64'(err_sticky), 64'(m_sticky));
        chk("err_pulse", 64'(err_pulse), 64'(m_pulse));
        chk("err_first", 64'(err_first), 64'(m_first));
        chk("err_first_vld", 64'(err_first_vld), 64'(m_fv));
        chk("err_count", 64'(err_count), 64'(m_cnt));
        chk("cov_sticky", 64'(cov_sticky), 64'(m_cov));
        for (int i = 0; i < NUM_CH; i++)
            chk($sformatf("xfer_count[%0d]", i), 64'(xfer_count[i*CNT_W +: CNT_W]), 64'(m_xfer[i]));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic go(input logic [5:0] s, input logic [NUM_CH-1:0] a);
        tc = s; dack = a;
        tick();
    endtask

    task automatic clear_pulse();
        err_clr = 1'b1; go(SI, '0); err_clr = 1'b0;
    endtask

    initial begin
        int cand[$];
        rst = 1; cs_n = 0; hrq = 0; hlda = 0; aen = 0; adstb = 0;
        ior_n = 1; iow_n = 1; memr_n = 1; memw_n = 1; err_clr = 0;
        dreq = '0; dack = '0; tc = SI;
        tick(); tick();
        chk("reset_sticky", 64'(err_sticky), 64'h0);
        chk("reset_xfer", 64'(xfer_count), 64'h0);
        rst = 0;
        tick();
        check_model();

        // Normal single transfer on channel 0.
        dreq = 4'b0001;
        go(SO, 4'b0000); go(S1, 4'b0001); go(S2, 4'b0001); go(S4, 4'b0001); go(SI, 4'b0000);
        chk("t1_sticky", 64'(err_sticky), 64'h00);
        chk("t1_xfer0", 64'(xfer_count[CNT_W-1:0]), 64'd1);
        chk("t1_cov", 64'(cov_sticky[5:0]), 64'b101111);
        check_model();

        // Illegal transition SO->S4.
        go(SO, '0); go(S4, '0);
        chk("t2_sticky", 64'(err_sticky), 64'h02);
        chk("t2_pulse", 64'(err_pulse), 64'd1);
        chk("t2_first", 64'(err_first), 64'd1);
        chk("t2_count", 64'(err_count), 64'd1);
        go(SI, '0);
        chk("t2_pulse_drop", 64'(err_pulse), 64'd0);
        check_model();

        // Non one-hot state masks the transition check.
        clear_pulse();
        go(6'b000011, '0);
        chk("t3_sticky", 64'(err_sticky), 64'h01);
        chk("t3_first", 64'(err_first), 64'd0);
        go(SI, '0);
        check_model();

        // Grant is channel 1, DACK on channel 2 with both IO strobes low.
        clear_pulse();
        dreq = 4'b0110;
        go(SO, '0);
        aen = 1; ior_n = 0; iow_n = 0;
        go(S1, 4'b0100);
        chk("t4_sticky", 64'(err_sticky), 64'h18);
        chk("t4_first", 64'(err_first), 64'd3);
        aen = 0; ior_n = 1; iow_n = 1;
        go(S2, '0); go(S4, '0); go(SI, '0);
        check_model();

        // Hold-request watchdog.
        clear_pulse();
        hrq = 1; hlda = 0;
        for (int c = 1; c <= 70; c++) begin
            tick();
            if (c == 64) chk("t5_before", 64'(err_sticky), 64'h00);
            if (c == 65) begin
                chk("t5_first_e6", 64'(err_sticky), 64'h40);
                chk("t5_count1", 64'(err_count), 64'd1);
            end
        end
        chk("t5_count6", 64'(err_count), 64'd6);
        chk("t5_cov7", 64'(cov_sticky[7]), 64'd1);
        err_clr = 1; tick(); err_clr = 0;
        chk("t5_clr_sticky", 64'(err_sticky), 64'h40);
        chk("t5_clr_count", 64'(err_count), 64'd1);
        hlda = 1; tick(); hrq = 0; hlda = 0; tick();
        check_model();

        // Channel-1 transfer counter saturation via block continuation.
        dreq = 4'b0010;
        go(SO, '0);
        repeat (CMAX) begin go(S1, 4'b0010); go(S2, 4'b0010); go(S4, 4'b0010); end
        go(SI, '0);
        chk("t6_sat", 64'(xfer_count[CNT_W +: CNT_W]), 64'(CMAX));
        chk("t6_cov6", 64'(cov_sticky[6]), 64'd1);
        go(SO, '0); go(S1, 4'b0010); go(S2, 4'b0010); go(S4, 4'b0010); go(SI, '0);
        chk("t6_hold", 64'(xfer_count[CNT_W +: CNT_W]), 64'(CMAX));
        check_model();

        // Reset mid-activity clears every output.
        go(SO, '0); go(S1, 4'b0010);
        rst = 1; tick();
        chk("rst_sticky", 64'(err_sticky), 64'h0);
        chk("rst_pulse", 64'(err_pulse), 64'h0);
        chk("rst_first", 64'(err_first), 64'h0);
        chk("rst_vld", 64'(err_first_vld), 64'h0);
        chk("rst_count", 64'(err_count), 64'h0);
        chk("rst_xfer", 64'(xfer_count), 64'h0);
        chk("rst_cov", 64'(cov_sticky), 64'h0);
        rst = 0;

        // Randomized run, mostly legal walks with occasional junk.
        repeat (600) begin
            rst = ($urandom_range(99) < 2);
            if ($urandom_range(9) == 0) tc = 6'($urandom);
            else begin
                cand.delete();
                for (int k = 0; k < 10; k++) if (lf[k] == m_prev) cand.push_back(lt[k]);
                tc = 6'b000001 << cand[$urandom_range(cand.size() - 1)];
            end
            dreq = NUM_CH'($urandom);
            case ($urandom_range(3))
                0: dack = '0;
                1: dack = (m_grant >= 0) ? NUM_CH'(1 << m_grant) : '0;
                2: dack = NUM_CH'(1 << $urandom_range(NUM_CH - 1));
                default: dack = NUM_CH'($urandom);
            endcase
            cs_n   = ($urandom_range(9) == 0);
            aen    = $urandom_range(1);
            ior_n  = ($urandom_range(3) != 0);
            iow_n  = ($urandom_range(3) != 0);
            memr_n = ($urandom_range(3) != 0);
            memw_n = ($urandom_range(3) != 0);
            adstb  = ($urandom_range(3) == 0);
            hrq    = ($urandom_range(7) != 0);
            hlda   = ($urandom_range(15) == 0);
            err_clr = ($urandom_range(19) == 0);
            tick();
            check_model();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
